// File: rtl/add_pkg.sv
// Shared constants for the bit-serial adder: FSM encoding and default operand width.
package add_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Start/result handshake bundle between a requester (master) and the serial adder (slave).
interface serial_add_ctrl_if
    import add_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (output start, a, b, cin, input ready, busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output ready, busy, done, sum, cout);
endinterface

// File: rtl/fa_cell.sv
// Combinational 1-bit full adder built from two half adders and an OR on their carries.
module fa_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    logic s1, c1, c2;

    ha u_ha0 (.a_i(a_i), .b_i(b_i), .s_o(s1),  .c_o(c1));
    ha u_ha1 (.a_i(s1),  .b_i(c_i), .s_o(s_o), .c_o(c2));

    assign c_o = c1 | c2;
endmodule

// File: rtl/ha.sv
// 1-bit half adder.
module ha (
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i;
    assign c_o = a_i & b_i;
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: feeds operands LSB-first through one shared fa_cell,
// holding the carry in a register between bits; result after WIDTH+1 cycles.
module serial_add_ctrl
    import add_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic            clk,
    input  logic            rst,
    serial_add_ctrl_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               fa_s, fa_c;

    fa_cell u_fa (
        .a_i(a_sh_q[0]),
        .b_i(b_sh_q[0]),
        .c_i(carry_q),
        .s_o(fa_s),
        .c_o(fa_c)
    );

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state, datapath update and status flags decoded from the next state
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    carry_d = bus.cin;
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                res_d   = (res_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
                carry_d = fa_c;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d == ST_RUN);
        done_d  = (state_d == ST_DONE);
    end

    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.sum   = res_q;
    assign bus.cout  = carry_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_add_ctrl;
    logic clk;
    logic rst;

    int n_checks = 0;
    int n_pass   = 0;

    logic [8:0] q8[$];
    logic [1:0] q1[$];
    logic       prev8 = 1'b0;
    logic       prev1 = 1'b0;

    serial_add_ctrl_if #(.WIDTH(8)) b8 ();
    serial_add_ctrl_if #(.WIDTH(1)) b1 ();

    serial_add_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(b8));
    serial_add_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumers: compare at every done and police the pulse width
    always @(negedge clk) begin
        if (b8.done === 1'b1) begin
            if (q8.size() == 0) check("spurious_done8", 64'(1), 64'(0));
            else check("result8", 64'({b8.cout, b8.sum}), 64'(q8.pop_front()));
            check("done_width8", 64'(prev8), 64'(0));
        end
        prev8 = (b8.done === 1'b1);
    end

    always @(negedge clk) begin
        if (b1.done === 1'b1) begin
            if (q1.size() == 0) check("spurious_done1", 64'(1), 64'(0));
            else check("result1", 64'({b1.cout, b1.sum}), 64'(q1.pop_front()));
            check("done_width1", 64'(prev1), 64'(0));
        end
        prev1 = (b1.done === 1'b1);
    end

    // Waits for ready, presents one request for a single cycle and records the expected result
    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic cin);
        int guard = 0;
        while (b8.ready !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        if (b8.ready !== 1'b1) check("ready_timeout8", 64'(0), 64'(1));
        b8.start = 1'b1;
        b8.a     = a;
        b8.b     = b;
        b8.cin   = cin;
        q8.push_back(9'(a) + 9'(b) + 9'(cin));
        tick();
        b8.start = 1'b0;
        b8.a     = 8'($urandom);
        b8.b     = 8'($urandom);
        b8.cin   = 1'($urandom);
    endtask

    task automatic issue1(input logic a, input logic b, input logic cin);
        int guard = 0;
        while (b1.ready !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        if (b1.ready !== 1'b1) check("ready_timeout1", 64'(0), 64'(1));
        b1.start = 1'b1;
        b1.a     = a;
        b1.b     = b;
        b1.cin   = cin;
        q1.push_back(2'(a) + 2'(b) + 2'(cin));
        tick();
        b1.start = 1'b0;
        b1.a     = 1'($urandom);
        b1.b     = 1'($urandom);
        b1.cin   = 1'($urandom);
    endtask

    task automatic wait_done8();
        int guard = 0;
        while (b8.done !== 1'b1 && guard < 40) begin
            tick();
            guard++;
        end
        if (b8.done !== 1'b1) check("done_timeout8", 64'(0), 64'(1));
    endtask

    initial begin
        b8.start = 1'b0; b8.a = '0; b8.b = '0; b8.cin = 1'b0;
        b1.start = 1'b0; b1.a = '0; b1.b = '0; b1.cin = 1'b0;

        rst = 1'b1;
        tick();
        tick();
        check("rst_ready", 64'(b8.ready), 64'(1));
        check("rst_busy",  64'(b8.busy),  64'(0));
        check("rst_done",  64'(b8.done),  64'(0));
        check("rst_sum",   64'(b8.sum),   64'(0));
        check("rst_cout",  64'(b8.cout),  64'(0));
        check("rst_ready1", 64'(b1.ready), 64'(1));
        rst = 1'b0;
        tick();

        // Latency and handshake timing for a simple add
        issue8(8'h0F, 8'h01, 1'b0);
        for (int i = 0; i < 8; i++) begin
            check("run_busy",  64'(b8.busy),  64'(1));
            check("run_ready", 64'(b8.ready), 64'(0));
            tick();
        end
        check("lat_done", 64'(b8.done), 64'(1));
        check("lat_busy", 64'(b8.busy), 64'(0));
        tick();
        check("post_ready", 64'(b8.ready), 64'(1));
        check("post_done",  64'(b8.done),  64'(0));
        check("held_sum",   64'(b8.sum),   64'(8'h10));
        check("held_cout",  64'(b8.cout),  64'(0));

        // Carry ripples through every bit
        issue8(8'hFF, 8'h01, 1'b1);
        wait_done8();
        tick();

        // Requests during RUN and in the done cycle are dropped
        issue8(8'h12, 8'h34, 1'b0);
        tick();
        b8.start = 1'b1; b8.a = 8'hAA; b8.b = 8'h55; b8.cin = 1'b1;
        tick();
        tick();
        tick();
        b8.start = 1'b0;
        wait_done8();
        b8.start = 1'b1; b8.a = 8'hAA; b8.b = 8'h55; b8.cin = 1'b0;
        tick();
        b8.start = 1'b0;
        check("done_start_ready", 64'(b8.ready), 64'(1));
        check("done_start_busy",  64'(b8.busy),  64'(0));
        for (int i = 0; i < 12; i++) tick();

        // Reset mid-run aborts the operation without a done pulse
        issue8(8'h20, 8'h30, 1'b0);
        tick();
        tick();
        tick();
        rst = 1'b1;
        q8.delete();
        b8.start = 1'b1;
        tick();
        check("midrst_ready", 64'(b8.ready), 64'(1));
        check("midrst_busy",  64'(b8.busy),  64'(0));
        check("midrst_done",  64'(b8.done),  64'(0));
        check("midrst_sum",   64'(b8.sum),   64'(0));
        check("midrst_cout",  64'(b8.cout),  64'(0));
        b8.start = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        issue8(8'd3, 8'd4, 1'b0);
        wait_done8();
        check("post_rst_sum", 64'(b8.sum), 64'(7));
        tick();

        // Back-to-back random traffic on both widths
        fork
            for (int i = 0; i < 1000; i++) issue8(8'($urandom), 8'($urandom), 1'($urandom));
            for (int i = 0; i < 1000; i++) issue1(1'($urandom), 1'($urandom), 1'($urandom));
        join
        for (int i = 0; i < 15; i++) tick();

        check("q8_drained", 64'(q8.size()), 64'(0));
        check("q1_drained", 64'(q1.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
